// File: rtl/branch_flag_unit.sv
// Branch flag generator: latches rs1/rs2/branch_type, registers Z/N/C/V; optional BRANCH_STATS_EN counters.
// Latency: inputs sampled at edge k are visible on the outputs after edge k+1 (two register stages).
// Backpressure: stall freezes both stages, flush clears both valids (flush wins); no ready output.
module branch_flag_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] rs1,
  input  logic [WIDTH-1:0] rs2,
  input  logic [2:0]       branch_type,
  input  logic             stall,
  input  logic             flush,
  output logic             Z,
  output logic             N,
  output logic             C,
  output logic             V,
  output logic [2:0]       branch_type_out,
  output logic             out_valid
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]      branch_count,
  output logic [31:0]      flush_count
`endif
);

  localparam int MSB = WIDTH - 1;

  localparam logic [2:0] BT_NONE = 3'b000;
  localparam logic [2:0] BT_RSVD = 3'b011;
  localparam logic [2:0] BT_BLTU = 3'b110;
  localparam logic [2:0] BT_BGEU = 3'b111;

  // Stage A: operand latch
  logic             a_vld;
  logic [WIDTH-1:0] a_rs1;
  logic [WIDTH-1:0] a_rs2;
  logic [2:0]       a_type;

  // Stage B: flag register (drives the outputs directly)
  logic             b_vld;
  logic [2:0]       b_type;
  logic             b_z, b_n, b_c, b_v;

  logic [2:0]       a_type_in;
  logic [WIDTH:0]   diff;
  logic             z_nxt, n_nxt, c_nxt, v_nxt;

  // Invalid slots and the reserved encoding both enter the pipe as "no branch".
  always_comb begin
    a_type_in = branch_type;
    if (!in_valid || branch_type == BT_RSVD) begin
      a_type_in = BT_NONE;
    end
  end

  always_comb begin
    diff  = {1'b0, a_rs1} - {1'b0, a_rs2};
    z_nxt = (diff[MSB:0] == '0);
    c_nxt = diff[WIDTH];
    v_nxt = (a_rs1[MSB] != a_rs2[MSB]) && (diff[MSB] != a_rs1[MSB]);
    n_nxt = diff[MSB] ^ v_nxt;
    if (a_type == BT_BLTU || a_type == BT_BGEU) begin
      n_nxt = c_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_vld  <= 1'b0;
      a_rs1  <= '0;
      a_rs2  <= '0;
      a_type <= BT_NONE;
      b_vld  <= 1'b0;
      b_type <= BT_NONE;
      b_z    <= 1'b0;
      b_n    <= 1'b0;
      b_c    <= 1'b0;
      b_v    <= 1'b0;
    end else if (flush) begin
      // Operands and flags are left as-is; only the liveness fields are killed.
      a_vld  <= 1'b0;
      a_type <= BT_NONE;
      b_vld  <= 1'b0;
      b_type <= BT_NONE;
    end else if (!stall) begin
      a_vld  <= in_valid;
      a_rs1  <= rs1;
      a_rs2  <= rs2;
      a_type <= a_type_in;
      b_vld  <= a_vld;
      b_type <= a_vld ? a_type : BT_NONE;
      b_z    <= z_nxt;
      b_n    <= n_nxt;
      b_c    <= c_nxt;
      b_v    <= v_nxt;
    end
  end

  assign Z               = b_z;
  assign N               = b_n;
  assign C               = b_c;
  assign V               = b_v;
  assign out_valid       = b_vld;
  assign branch_type_out = b_vld ? b_type : BT_NONE;

`ifdef BRANCH_STATS_EN
  logic retire;
  logic flush_hit;

  // A branch is counted when it leaves stage B, not when it arrives.
  assign retire    = !stall && !flush && b_vld && (b_type != BT_NONE);
  assign flush_hit = flush && ((a_vld && a_type != BT_NONE) || (b_vld && b_type != BT_NONE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_count <= '0;
      flush_count  <= '0;
    end else begin
      if (retire && branch_count != 32'hFFFF_FFFF) begin
        branch_count <= branch_count + 32'd1;
      end
      if (flush_hit && flush_count != 32'hFFFF_FFFF) begin
        flush_count <= flush_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_flag_unit.sv
// Directed testbench for branch_flag_unit; also covers the counters when BRANCH_STATS_EN is defined.
module tb_branch_flag_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [2:0]  branch_type;
  logic        stall;
  logic        flush;
  logic        Z, N, C, V;
  logic [2:0]  branch_type_out;
  logic        out_valid;
`ifdef BRANCH_STATS_EN
  logic [31:0] branch_count;
  logic [31:0] flush_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  branch_flag_unit #(.WIDTH(32)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .rs1             (rs1),
    .rs2             (rs2),
    .branch_type     (branch_type),
    .stall           (stall),
    .flush           (flush),
    .Z               (Z),
    .N               (N),
    .C               (C),
    .V               (V),
    .branch_type_out (branch_type_out),
    .out_valid       (out_valid)
`ifdef BRANCH_STATS_EN
    ,
    .branch_count    (branch_count),
    .flush_count     (flush_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] bt, input logic st, input logic fl);
    in_valid    = v;
    rs1         = a;
    rs2         = b;
    branch_type = bt;
    stall       = st;
    flush       = fl;
  endtask

  task automatic idle();
    drive(1'b0, 32'd0, 32'd0, 3'b000, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    idle();
    #2 rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    #12;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_checks++; if ({Z, N, C, V} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags got %b want 0000", {Z, N, C, V}); end
    n_checks++; if (branch_type_out !== 3'b000) begin n_fail++; $display("FAIL reset_bt got %b want 000", branch_type_out); end
`ifdef BRANCH_STATS_EN
    n_checks++; if (branch_count !== 32'd0 || flush_count !== 32'd0) begin n_fail++; $display("FAIL reset_counts got %0d/%0d want 0/0", branch_count, flush_count); end
`endif
    rst_n = 1'b1;
    tick();
    // Put a live BEQ into stage B, then yank reset between edges.
    drive(1'b1, 32'h55, 32'h55, 3'b010, 1'b0, 1'b0);
    tick();
    idle();
    tick();
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL midreset_pre_valid got %b want 1", out_valid); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_async_valid got %b want 0", out_valid); end
    n_checks++; if (Z !== 1'b0 || branch_type_out !== 3'b000) begin n_fail++; $display("FAIL midreset_async_out got Z=%b bt=%b want Z=0 bt=000", Z, branch_type_out); end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset[%0d] got %b want 0", i, out_valid); end
    end
  endtask

  task automatic test_beq();
    drive(1'b1, 32'h0000_1234, 32'h0000_1234, 3'b010, 1'b0, 1'b0);
    tick();
    idle();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL beq_latency_bubble got %b want 0", out_valid); end
    tick();
    n_checks++; if ({Z, N, C, V} !== 4'b1000) begin n_fail++; $display("FAIL beq_flags got ZNCV=%b want 1000", {Z, N, C, V}); end
    n_checks++; if (branch_type_out !== 3'b010 || out_valid !== 1'b1) begin n_fail++; $display("FAIL beq_type got bt=%b v=%b want 010/1", branch_type_out, out_valid); end
  endtask

  task automatic test_signed_unsigned();
    drive(1'b1, 32'hFFFF_FFFF, 32'h1, 3'b100, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'hFFFF_FFFF, 32'h1, 3'b110, 1'b0, 1'b0);
    tick();
    idle();
    n_checks++; if (N !== 1'b1 || C !== 1'b0 || branch_type_out !== 3'b100) begin n_fail++; $display("FAIL blt got N=%b C=%b bt=%b want 1/0/100", N, C, branch_type_out); end
    tick();
    n_checks++; if ({Z, N, C} !== 3'b000 || branch_type_out !== 3'b110) begin n_fail++; $display("FAIL bltu got ZNC=%b bt=%b want 000/110", {Z, N, C}, branch_type_out); end
    tick();
  endtask

  task automatic test_overflow();
    drive(1'b1, 32'h8000_0000, 32'h1, 3'b101, 1'b0, 1'b0);
    tick();
    idle();
    tick();
    n_checks++; if ({N, C, V} !== 3'b101) begin n_fail++; $display("FAIL bge_overflow got NCV=%b want 101", {N, C, V}); end
    n_checks++; if (branch_type_out !== 3'b101 || out_valid !== 1'b1) begin n_fail++; $display("FAIL bge_type got bt=%b v=%b want 101/1", branch_type_out, out_valid); end
  endtask

  task automatic test_stall_flush();
    do_reset();
    // BNE 5 vs 7: diff = -2 -> Z=0 N=1 C=1 V=0
    drive(1'b1, 32'd5, 32'd7, 3'b001, 1'b0, 1'b0);
    tick();
    idle();
    tick();
    n_checks++; if ({Z, N, C, V} !== 4'b0110 || branch_type_out !== 3'b001) begin n_fail++; $display("FAIL bne_before_stall got ZNCV=%b bt=%b want 0110/001", {Z, N, C, V}, branch_type_out); end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'd9, 32'd9, 3'b010, 1'b1, 1'b0);
      tick();
      n_checks++;
      if ({Z, N, C, V} !== 4'b0110 || branch_type_out !== 3'b001 || out_valid !== 1'b1) begin
        n_fail++; $display("FAIL stall_hold[%0d] got ZNCV=%b bt=%b v=%b want 0110/001/1", i, {Z, N, C, V}, branch_type_out, out_valid);
      end
    end
    drive(1'b1, 32'd9, 32'd9, 3'b010, 1'b1, 1'b1);
    tick();
    idle();
    n_checks++; if (out_valid !== 1'b0 || branch_type_out !== 3'b000) begin n_fail++; $display("FAIL flush_over_stall got v=%b bt=%b want 0/000", out_valid, branch_type_out); end
`ifdef BRANCH_STATS_EN
    n_checks++; if (flush_count !== 32'd1 || branch_count !== 32'd0) begin n_fail++; $display("FAIL flush_counts got f=%0d b=%0d want 1/0", flush_count, branch_count); end
`endif
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_no_ghost got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  bt_in  [4];
    logic [31:0] a_in   [4];
    logic [31:0] b_in   [4];
    logic [2:0]  bt_exp [4];
    logic [1:0]  zn_exp [4];
    bt_in  = '{3'b010, 3'b001, 3'b110, 3'b011};
    a_in   = '{32'd1, 32'd3, 32'hFFFF_FFFF, 32'd0};
    b_in   = '{32'd1, 32'd4, 32'd1, 32'd0};
    bt_exp = '{3'b010, 3'b001, 3'b110, 3'b000};
    zn_exp = '{2'b10, 2'b01, 2'b00, 2'b00};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      if (i < 4) drive(1'b1, a_in[i], b_in[i], bt_in[i], 1'b0, 1'b0);
      else idle();
      tick();
      if (i >= 1) begin
        n_checks++;
        if (branch_type_out !== bt_exp[i-1]) begin n_fail++; $display("FAIL b2b_type[%0d] got %b want %b", i - 1, branch_type_out, bt_exp[i-1]); end
        if (i <= 3) begin
          n_checks++;
          if ({Z, N} !== zn_exp[i-1] || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL b2b_flags[%0d] got ZN=%b v=%b want %b/1", i - 1, {Z, N}, out_valid, zn_exp[i-1]);
          end
        end
      end
    end
`ifdef BRANCH_STATS_EN
    n_checks++; if (branch_count !== 32'd3) begin n_fail++; $display("FAIL b2b_branch_count got %0d want 3", branch_count); end
`endif
    tick();
    n_checks++; if (out_valid !== 1'b0 || branch_type_out !== 3'b000) begin n_fail++; $display("FAIL b2b_drain got v=%b bt=%b want 0/000", out_valid, branch_type_out); end
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    test_reset();
    test_beq();
    test_signed_unsigned();
    test_overflow();
    test_stall_flush();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_flag_unit.md
# branch_flag_unit

- Pipelined flag generator that drives `CONDITION_HANDLER`.
- Compares rs1 against rs2 for each branch instruction and produces registered Z/N/C/V flags together with a matching branch_type.
- Sits in the EX stage, between the operand-forwarding muxes and `CONDITION_HANDLER`.
- Honours pipeline stall and flush, so `CONDITION_HANDLER` only sees a branch_type other than 000 for live, valid branches.

## Interface
Parameters:
- WIDTH, 32, operand width in bits (≥ 2).

Ports:
- clk  input  1  rising-edge clock; the block's only clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  rs1/rs2/branch_type are valid this cycle.
- rs1  input  WIDTH  first operand.
- rs2  input  WIDTH  second operand.
- branch_type  input  3  000 none, 001 BNE, 010 BEQ, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU; 011 reserved.
- stall  input  1  hold both stages.
- flush  input  1  kill both stages.
- Z  output  1  rs1 == rs2.
- N  output  1  rs1 < rs2, signed or unsigned per branch_type.
- C  output  1  unsigned borrow of rs1 − rs2.
- V  output  1  signed overflow of rs1 − rs2.
- branch_type_out  output  3  branch_type aligned with the flags; forced to 000 when out_valid = 0.
- out_valid  output  1  flags belong to a live instruction.
- branch_count  output  32  present only with BRANCH_STATS_EN.
- flush_count  output  32  present only with BRANCH_STATS_EN.

## Operation
Stage A (operand latch):
- Captures in_valid, rs1, rs2, branch_type.
- Reserved code 011 is latched as 000.

Stage B (flag register). Flags are computed from the stage-A contents:
- diff = {1'b0, rs1} − {1'b0, rs2}, WIDTH+1 bits.
- Z = (diff[WIDTH−1:0] == 0).
- C = diff[WIDTH].
- V = (rs1[MSB] ≠ rs2[MSB]) && (diff[WIDTH−1] ≠ rs1[MSB]).
- N = C when branch_type is 110 or 111; otherwise N = diff[WIDTH−1] XOR V (signed less-than).

Stage behaviour:
- A stage with valid = 0 holds branch_type 000.
- Flags are still computed for type 000, but they are don't-care.
- Stall = 1: both stages hold every field and the inputs are ignored.
- Flush = 1: both stages clear valid and branch_type to 000. Flags are left as don't-care.
- Flush has priority over stall.
- Stall and flush both 0: A ← inputs, B ← A.

## Timing
- Reset (async assert, sync-released by the parent): every register and every output is 0, including the counters.
- Latency: inputs sampled at edge k appear on the outputs after edge k+1. That is two register stages and one cycle of bubble.
- Throughput is one branch per cycle.
- Outputs come straight from registers, with no combinational path from inputs to outputs.
- Reset asserted mid-operation: in-flight branches are discarded immediately. out_valid falls asynchronously.
- Flush and in_valid in the same cycle: the incoming instruction is also discarded.
- Stall released: the next edge advances normally, with no duplicated or lost entries.

## Configuration
BRANCH_STATS_EN:
- Defined:
  - branch_count increments on each edge where stage B advances (stall = 0, flush = 0) while holding out_valid = 1 and branch_type_out ≠ 000.
  - flush_count increments on each edge where flush = 1 and either stage held a valid branch.
  - Both counters saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: both counter ports and their logic are absent, and the remaining behaviour is identical.

## Test plan
- Reset: drive rst_n = 0 mid-stream → all outputs 0 asynchronously; after release and with idle inputs, out_valid stays 0.
- BEQ, rs1 = rs2 = 32'h0000_1234, in_valid = 1 at edge 0 → after edge 1: Z = 1, N = 0, C = 0, V = 0, branch_type_out = 010, out_valid = 1.
- Signed vs unsigned, rs1 = 32'hFFFF_FFFF, rs2 = 1:
  - BLT → N = 1, C = 0.
  - BLTU → N = 0, C = 0, Z = 0.
- Overflow, rs1 = 32'h8000_0000, rs2 = 1, BGE → V = 1, N = 1 (signed less-than), C = 0.
- Stall and flush:
  - Issue BNE, then hold stall = 1 for 3 cycles → outputs stay frozen.
  - Assert flush together with stall → next edge gives out_valid = 0, branch_type_out = 000.
  - With BRANCH_STATS_EN: flush_count = 1, branch_count = 0.
- Back-to-back BEQ, BNE, BLTU, then reserved code 011 → outputs appear in order, one per cycle, and the 011 entry emerges as branch_type_out = 000; with BRANCH_STATS_EN, branch_count = 3.
